// File: rtl/dcache_pkg.sv
// Shared types and constants for the D-cache responder slice.
package dcache_pkg;

    // Responder FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } dcache_resp_state_e;

    // Request type encoding carried in bit 0 of the arbiter's selected_type.
    localparam logic REQ_LOAD  = 1'b0;
    localparam logic REQ_STORE = 1'b1;

    // Width of a port index; a single-port build still gets one bit.
    function automatic int sel_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// Arbiter-side and memory-side signal bundle of the D-cache responder.
//
// Handshakes:
//   - Arbiter side: the arbiter presents a request with grant != 0.
//     The responder takes it only while resp_ready is 1.
//     resp_done is a one-cycle pulse that closes the request.
//   - Memory request: a transfer happens on a cycle with
//     mem_req_valid && mem_req_ready.
//     While mem_req_valid is high, we/addr/wdata are stable.
//   - Memory response: mem_resp_valid has no ready.
//     The responder always consumes it, except in IDLE, where it is dropped.
interface dcache_responder_if
#(
    parameter int NUM_PORTS  = 2,
    parameter int PORT_WIDTH = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import dcache_pkg::*;

    localparam int SEL_W = sel_width(NUM_PORTS);

    logic [NUM_PORTS-1:0]            grant;
    logic [SEL_W-1:0]                selected_port;
    logic [PORT_WIDTH-1:0]           selected_type;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            req_abort;
    logic                            resp_ready;
    logic                            resp_done;
    logic                            mem_req_valid;
    logic                            mem_req_ready;
    logic                            mem_req_we;
    logic [ADDR_WIDTH-1:0]           mem_req_addr;
    logic [DATA_WIDTH-1:0]           mem_req_wdata;
    logic                            mem_resp_valid;
    logic [DATA_WIDTH-1:0]           mem_resp_rdata;
    logic [NUM_PORTS-1:0]            port_resp_valid;
    logic [DATA_WIDTH-1:0]           port_resp_rdata;
    logic                            port_resp_err;

    // Responder view.
    modport slave (
        input  grant, selected_port, selected_type, req_addr, req_wdata, req_abort,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output resp_ready, resp_done, mem_req_valid, mem_req_we, mem_req_addr,
        output mem_req_wdata, port_resp_valid, port_resp_rdata, port_resp_err
    );

    // Arbiter/memory view.
    modport master (
        output grant, selected_port, selected_type, req_addr, req_wdata, req_abort,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  resp_ready, resp_done, mem_req_valid, mem_req_we, mem_req_addr,
        input  mem_req_wdata, port_resp_valid, port_resp_rdata, port_resp_err
    );

endinterface

// File: rtl/dcache_resp_timer.sv
// Saturating WAIT-phase timer.
// expired is high once LIMIT-1 has been reached.
module dcache_resp_timer
#(
    parameter int LIMIT = 255
)
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int            W    = $clog2(LIMIT + 1);
    localparam logic [W-1:0]  LAST = W'(LIMIT - 1);
    localparam logic [W-1:0]  MAX  = '1;

    logic [W-1:0] count;

    // Count enabled cycles; stop at all-ones so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count >= LAST);

endmodule

// File: rtl/dcache_responder.sv
// D-cache responder.
// Turns one arbiter grant into one memory transaction and returns the
// result to the granted port. It also handles aborts and memory timeouts.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int PORT_WIDTH     = 1,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic               clk,
    input  logic               rst,
    dcache_responder_if.slave  bus,
    output dcache_resp_state_e state_dbg
);
    localparam int SEL_W = sel_width(NUM_PORTS);

    dcache_resp_state_e     state;
    logic [SEL_W-1:0]       port_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   ready_q;
    logic                   done_q;
    logic                   mvalid_q;
    logic [NUM_PORTS-1:0]   prv_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   err_q;

    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [NUM_PORTS-1:0]   port_onehot;
    logic                   abort_hit;
    logic                   timer_expired;

    // Select the granted port's address/data, and decode the latched owner
    // as a one-hot vector.
    always_comb begin
        sel_addr    = '0;
        sel_wdata   = '0;
        port_onehot = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.selected_port == SEL_W'(p)) begin
                sel_addr  = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
            port_onehot[p] = (port_q == SEL_W'(p));
        end
    end

    // Only the owning port's abort line matters.
    assign abort_hit = |(bus.req_abort & port_onehot);

    dcache_resp_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state == ISSUE) && bus.mem_req_ready),
        .enable  (state == WAIT),
        .expired (timer_expired)
    );

    // Transaction FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            port_q   <= '0;
            we_q     <= REQ_LOAD;
            addr_q   <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            mvalid_q <= 1'b0;
            prv_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.grant) begin
                        port_q   <= bus.selected_port;
                        we_q     <= bus.selected_type[0];
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        mvalid_q <= 1'b1;
                        ready_q  <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        // Handshake done: the request is committed even if
                        // an abort arrives in this same cycle.
                        mvalid_q <= 1'b0;
                        state    <= abort_hit ? DRAIN : WAIT;
                    end else if (abort_hit) begin
                        mvalid_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                WAIT: begin
                    if (abort_hit) begin
                        if (bus.mem_resp_valid) begin
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            state   <= DRAIN;
                        end
                    end else if (bus.mem_resp_valid) begin
                        rdata_q <= (we_q == REQ_STORE) ? '0 : bus.mem_resp_rdata;
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        prv_q   <= port_onehot;
                        state   <= DONE;
                    end else if (timer_expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        prv_q   <= port_onehot;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    prv_q   <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                DRAIN: begin
                    if (bus.mem_resp_valid) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    done_q   <= 1'b0;
                    prv_q    <= '0;
                    mvalid_q <= 1'b0;
                    ready_q  <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.resp_ready      = ready_q;
    assign bus.resp_done       = done_q;
    assign bus.mem_req_valid   = mvalid_q;
    assign bus.mem_req_we      = we_q;
    assign bus.mem_req_addr    = addr_q;
    assign bus.mem_req_wdata   = wdata_q;
    assign bus.port_resp_valid = prv_q;
    assign bus.port_resp_rdata = rdata_q;
    assign bus.port_resp_err   = err_q;
    assign state_dbg           = state;

endmodule

// File: tb/tb_dcache_responder.sv
// Testbench for dcache_responder.
// Each transaction is described by a scenario: port, type, request stall,
// response delay and an optional abort. A timeline of the expected outputs
// for every cycle is built from that scenario.
module tb_dcache_responder;
    import dcache_pkg::*;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = 1;
    localparam int T  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_responder_if #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
    dcache_resp_state_e state_dbg;

    dcache_responder #(
        .NUM_PORTS(NP), .PORT_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    typedef struct packed {
        logic          ready;
        logic          done;
        logic          mvalid;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NP-1:0] prv;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // ---------------- monitor ----------------
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            mv_cnt   = 0;
    logic [NP-1:0] last_prv;
    logic [DW-1:0] last_rdata;
    logic          last_err;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.resp_done) begin
            done_cnt   = done_cnt + 1;
            done_cyc   = cyc;
            last_prv   = bus.port_resp_valid;
            last_rdata = bus.port_resp_rdata;
            last_err   = bus.port_resp_err;
        end
        if (bus.mem_req_valid) mv_cnt = mv_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("resp_ready", 64'(bus.resp_ready), 64'(e.ready));
            check("resp_done", 64'(bus.resp_done), 64'(e.done));
            check("mem_req_valid", 64'(bus.mem_req_valid), 64'(e.mvalid));
            check("port_resp_valid", 64'(bus.port_resp_valid), 64'(e.prv));
            if (e.mvalid) begin
                check("mem_req_we", 64'(bus.mem_req_we), 64'(e.we));
                check("mem_req_addr", 64'(bus.mem_req_addr), 64'(e.addr));
                check("mem_req_wdata", 64'(bus.mem_req_wdata), 64'(e.wdata));
            end
            if (e.prv != '0) begin
                check("port_resp_rdata", 64'(bus.port_resp_rdata), 64'(e.rdata));
                check("port_resp_err", 64'(bus.port_resp_err), 64'(e.err));
            end
        end
    end

    // ---------------- model helpers ----------------
    function automatic exp_t mk(input logic ready, input logic done, input logic mvalid,
                                input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [NP-1:0] prv,
                                input logic [DW-1:0] rdata, input logic err);
        exp_t e;
        e.ready = ready; e.done = done; e.mvalid = mvalid; e.we = we;
        e.addr = addr; e.wdata = wdata; e.prv = prv; e.rdata = rdata; e.err = err;
        return e;
    endfunction

    function automatic exp_t idle_e();
        return mk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    endfunction

    function automatic exp_t busy_e();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    endfunction

    // Queue this cycle's expectation and advance to just after the next edge.
    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    int grant_cyc = 0;

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.grant          = '0;
            bus.req_abort      = NP'($urandom);
            bus.mem_resp_valid = 1'($urandom);
            bus.mem_req_ready  = 1'($urandom);
            bus.mem_resp_rdata = $urandom;
            step(idle_e());
        end
        bus.req_abort      = '0;
        bus.mem_resp_valid = 1'b0;
    endtask

    // One transaction.
    // stall:    ISSUE cycles with mem_req_ready low before the handshake.
    // delay:    WAIT/DRAIN cycle index on which mem_resp_valid arrives
    //           (a value >= T means it never arrives in time).
    // ab_phase: 0 = no abort, 1 = abort in ISSUE cycle ab_at,
    //           2 = abort in WAIT cycle ab_at.
    task automatic txn(input int port, input logic typ, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] rd,
                       input int stall, input int delay, input int ab_phase, input int ab_at);
        logic [NP-1:0] oh;
        logic          drain;
        logic          abort_now;
        logic [DW-1:0] res;
        logic          err;
        int            w;
        exp_t          iss;
        oh        = '0;
        oh[port]  = 1'b1;
        drain     = 1'b0;
        res       = '0;
        err       = 1'b0;
        iss       = mk(1'b0, 1'b0, 1'b1, typ, addr, wdata, '0, '0, 1'b0);

        // Grant cycle (responder idle).
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        bus.req_addr[port*AW +: AW]  = addr;
        bus.req_wdata[port*DW +: DW] = wdata;
        bus.grant          = oh;
        bus.selected_port  = 1'(port);
        bus.selected_type  = typ;
        bus.req_abort      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        grant_cyc          = cyc;
        step(idle_e());

        // Sources change after the grant has been taken.
        bus.req_addr      = {$urandom, $urandom};
        bus.req_wdata     = {$urandom, $urandom};
        bus.selected_port = 1'($urandom);
        bus.selected_type = 1'($urandom);

        // Request phase.
        for (int i = 0; i <= stall; i++) begin
            bus.mem_req_ready = (i == stall);
            bus.req_abort     = NP'($urandom) & ~oh;
            if (ab_phase == 1 && i == ab_at) bus.req_abort = bus.req_abort | oh;
            step(iss);
            if (ab_phase == 1 && i == ab_at) begin
                if (i < stall) begin
                    bus.grant = '0; bus.req_abort = '0; bus.mem_req_ready = 1'b0;
                    return;
                end
                drain = 1'b1;
            end
        end

        // Response phase.
        w = 0;
        while (1) begin
            abort_now          = (ab_phase == 2) && (w == ab_at) && !drain;
            bus.mem_req_ready  = 1'($urandom);
            bus.mem_resp_valid = (w == delay);
            bus.mem_resp_rdata = (w == delay) ? rd : DW'($urandom);
            bus.req_abort      = NP'($urandom) & ~oh;
            if (abort_now || (drain && 1'($urandom))) bus.req_abort = bus.req_abort | oh;
            step(busy_e());
            if (drain || abort_now) begin
                if (w == delay) begin
                    bus.grant = '0; bus.req_abort = '0; bus.mem_resp_valid = 1'b0;
                    return;
                end
                drain = 1'b1;
            end else if (w == delay) begin
                res = (typ == REQ_STORE) ? '0 : rd;
                err = 1'b0;
                break;
            end else if (w == T - 1) begin
                res = '0;
                err = 1'b1;
                break;
            end
            w++;
        end

        // Completion cycle; an abort here is ignored.
        bus.grant          = '0;
        bus.mem_resp_valid = 1'b0;
        bus.req_abort      = NP'($urandom);
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, oh, res, err));

        // After a timeout the late response lands in IDLE and must vanish.
        bus.req_abort      = '0;
        bus.mem_resp_valid = err;
        if (err) step(idle_e());
        bus.mem_resp_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int dc0;
    int mv0;

    initial begin
        rst = 1'b1;
        bus.grant = '0; bus.selected_port = '0; bus.selected_type = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_abort = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'(state_dbg), 64'(IDLE));
        check("reset_addr", 64'(bus.mem_req_addr), 64'h0);
        step(idle_e());
        rst = 1'b0;
        idle_cycles(2);

        // Best-case load on port 1.
        txn(1, REQ_LOAD, 32'h40, 32'h5555_AAAA, 32'hDEAD_BEEF, 0, 0, 0, 0);
        check("load_latency", 64'(done_cyc - grant_cyc), 64'd3);
        check("load_prv", 64'(last_prv), 64'h2);
        check("load_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
        check("load_err", 64'(last_err), 64'h0);
        idle_cycles(1);

        // Store on port 0 with a 5-cycle stall.
        mv0 = mv_cnt;
        txn(0, REQ_STORE, 32'h80, 32'h1234, 32'hFFFF_FFFF, 5, 1, 0, 0);
        check("store_mvalid_cycles", 64'(mv_cnt - mv0), 64'd6);
        check("store_prv", 64'(last_prv), 64'h1);
        check("store_rdata", 64'(last_rdata), 64'h0);
        idle_cycles(1);

        // Timeout with a late response in IDLE.
        dc0 = done_cnt;
        txn(0, REQ_LOAD, 32'h100, 32'h0, 32'h1111_2222, 1, 100, 0, 0);
        check("timeout_latency", 64'(done_cyc - grant_cyc), 64'd7);
        check("timeout_err", 64'(last_err), 64'h1);
        check("timeout_single_done", 64'(done_cnt - dc0), 64'd1);
        idle_cycles(1);

        // Abort in WAIT, response three cycles later.
        dc0 = done_cnt;
        txn(0, REQ_LOAD, 32'h200, 32'h0, 32'h3333_4444, 0, 3, 2, 0);
        idle_cycles(1);
        check("wait_abort_no_done", 64'(done_cnt - dc0), 64'd0);

        // Abort in ISSUE while the request is stalled.
        dc0 = done_cnt;
        txn(0, REQ_STORE, 32'h300, 32'h77, 32'h0, 3, 0, 1, 1);
        idle_cycles(2);
        check("issue_abort_no_done", 64'(done_cnt - dc0), 64'd0);

        // Reset while in WAIT.
        bus.req_addr  = {32'h0, 32'hABC0};
        bus.req_wdata = '0;
        bus.grant = 2'b01; bus.selected_port = 1'b0; bus.selected_type = REQ_LOAD;
        step(idle_e());
        bus.mem_req_ready = 1'b1;
        step(mk(1'b0, 1'b0, 1'b1, REQ_LOAD, 32'hABC0, '0, '0, '0, 1'b0));
        bus.mem_req_ready = 1'b0;
        step(busy_e());
        rst = 1'b1;
        step(busy_e());
        rst = 1'b0;
        bus.grant = '0;
        bus.mem_resp_valid = 1'b1;
        check("rst_wait_state", 64'(state_dbg), 64'(IDLE));
        check("rst_wait_addr", 64'(bus.mem_req_addr), 64'h0);
        step(idle_e());
        bus.mem_resp_valid = 1'b0;
        idle_cycles(1);
        txn(1, REQ_LOAD, 32'h44, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0);
        check("post_rst_rdata", 64'(last_rdata), 64'hCAFE_F00D);
        idle_cycles(1);

        // Randomized scenarios.
        for (int n = 0; n < 60; n++) begin
            int port, stall, delay, ph, at;
            port  = int'($urandom_range(0, 1));
            stall = int'($urandom_range(0, 3));
            delay = int'($urandom_range(0, 6));
            ph    = int'($urandom_range(0, 3));
            if (ph == 3) ph = 0;
            at    = (ph == 1) ? int'($urandom_range(0, stall)) : int'($urandom_range(0, 5));
            txn(port, 1'($urandom), $urandom, $urandom, $urandom, stall, delay, ph, at);
            idle_cycles(int'($urandom_range(1, 3)));
        end

        idle_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
